systolic_ctrl: RTL and testbench

Sequencing controller for a SIZE x SIZE output-stationary systolic array of `block` multiply-accumulate PEs. It accepts a start command with an inner-dimension length, clears the PE accumulators, and issues operand-buffer reads. It generates the skewed per-lane operand enables that feed the array edges, then drains the SIZE result rows through a valid/ready handshake. It sits between the host command interface and the array/operand-buffer datapath. It carries no operand data itself.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_ctrl_skew.sv | 34 +++
 rtl/systolic_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic array controller
package systolic_pkg;

  localparam int DEF_SIZE  = 4;
  localparam int DEF_K_MAX = 256;

  // Width needed to hold an inner-dimension length of 0..k_max
  function automatic int kw_of(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/systolic_ctrl_skew.sv
// rtl/systolic_ctrl_skew.sv - lane enable skew shift register (lane i = input delayed 1+i)
module ctrl_skew #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            din,
  output logic [SIZE-1:0] lane_en
);

  logic [SIZE-1:0] shift_q;
  logic [SIZE-1:0] shift_d;

  // Shift toward higher lanes each cycle; flush empties the whole pipe
  always_comb begin
    shift_d = {shift_q[SIZE-2:0], din};
    if (flush) begin
      shift_d = '0;
    end
  end

  // Skew pipe register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign lane_en = shift_q;

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - output-stationary systolic array sequencer (optional SYSTOLIC_CTRL_PERF_EN busy-cycle counter)
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int SIZE  = DEF_SIZE,
  parameter int K_MAX = DEF_K_MAX,
  parameter int KW    = kw_of(K_MAX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     abort,
  output logic                     busy,
  output logic                     cmd_err,
  output logic                     array_clr,
  output logic                     rd_en,
  output logic [KW-1:0]            rd_k,
  output logic [SIZE-1:0]          lane_en,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [$clog2(SIZE)-1:0]  result_row,
  output logic                     done
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int RW = $clog2(SIZE);
  // Wide enough for k_len + 2*SIZE without wrapping at K_MAX
  localparam int TW = KW + $clog2(2 * SIZE) + 1;

  localparam logic [KW-1:0] K_MAX_V  = KW'(K_MAX);
  localparam logic [TW-1:0] SKEW_CYC = TW'(2 * SIZE);
  localparam logic [RW-1:0] R_LAST   = RW'(SIZE - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [TW-1:0]   t_q, t_d;
  logic [RW-1:0]   r_q, r_d;
  logic            cmd_err_q, cmd_err_d;
  logic            array_clr_q, array_clr_d;
  logic            rd_en_q, rd_en_d;
  logic [KW-1:0]   rd_k_q, rd_k_d;
  logic            k_bad;
  logic [TW-1:0]   t_last;

  assign k_bad  = (k_len == '0) || (k_len > K_MAX_V);
  assign t_last = TW'(k_len_q) + SKEW_CYC - TW'(1);

  // Next-state, counters and registered-output precomputation
  always_comb begin
    state_d   = state_q;
    k_len_d   = k_len_q;
    t_d       = t_q;
    r_d       = r_q;
    cmd_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        t_d = '0;
        r_d = '0;
        if (start) begin
          if (k_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            k_len_d = k_len;
            state_d = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        t_d     = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (t_q == t_last) begin
          t_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      ST_DRAIN: begin
        if (result_ready) begin
          if (r_q == R_LAST) begin
            r_d     = '0;
            state_d = ST_DONE;
          end else begin
            r_d = r_q + RW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything once an operation is in flight
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      t_d     = '0;
      r_d     = '0;
    end

    array_clr_d = (state_d == ST_CLEAR);
    rd_en_d     = (state_d == ST_FEED) && (t_d < TW'(k_len_d));
    rd_k_d      = rd_en_d ? t_d[KW-1:0] : '0;
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      t_q         <= '0;
      r_q         <= '0;
      cmd_err_q   <= 1'b0;
      array_clr_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_k_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      t_q         <= t_d;
      r_q         <= r_d;
      cmd_err_q   <= cmd_err_d;
      array_clr_q <= array_clr_d;
      rd_en_q     <= rd_en_d;
      rd_k_q      <= rd_k_d;
    end
  end

  ctrl_skew #(
    .SIZE (SIZE)
  ) u_skew (
    .clk     (clk),
    .rst     (rst),
    .flush   (abort),
    .din     (rd_en_q),
    .lane_en (lane_en)
  );

  assign busy         = (state_q != ST_IDLE);
  assign cmd_err      = cmd_err_q;
  assign array_clr    = array_clr_q;
  assign rd_en        = rd_en_q;
  assign rd_k         = rd_k_q;
  assign result_valid = (state_q == ST_DRAIN);
  assign result_row   = r_q;
  assign done         = (state_q == ST_DONE);

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on accepted start, saturating, held while idle
  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start && !k_bad) begin
      perf_d = '0;
    end else if ((state_q != ST_IDLE) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - directed self-checking bench for systolic_ctrl
module tb_systolic_ctrl;

  localparam int SIZE  = 4;
  localparam int K_MAX = 256;
  localparam int KW    = 9;

  logic            clk;
  logic            rst;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            abort;
  logic            busy;
  logic            cmd_err;
  logic            array_clr;
  logic            rd_en;
  logic [KW-1:0]   rd_k;
  logic [SIZE-1:0] lane_en;
  logic            result_valid;
  logic            result_ready;
  logic [1:0]      result_row;
  logic            done;
  logic [31:0]     perf_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_ctrl #(
    .SIZE  (SIZE),
    .K_MAX (K_MAX),
    .KW    (KW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .k_len        (k_len),
    .abort        (abort),
    .busy         (busy),
    .cmd_err      (cmd_err),
    .array_clr    (array_clr),
    .rd_en        (rd_en),
    .rd_k         (rd_k),
    .lane_en      (lane_en),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_row   (result_row),
`ifdef SYSTOLIC_CTRL_PERF_EN
    .perf_cycles  (perf_cycles),
`endif
    .done         (done)
  );

`ifndef SYSTOLIC_CTRL_PERF_EN
  assign perf_cycles = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_err"}, cmd_err, 0);
    chk({tag, "_array_clr"}, array_clr, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_k"}, rd_k, 0);
    chk({tag, "_lane_en"}, lane_en, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_result_row"}, result_row, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [3:0] exp_lane;
    logic       exp_valid;
    int         cyc;
    int         exp_row;
    int         done_at;
    int         rd_cnt;

    rst          = 1'b0;
    start        = 1'b0;
    k_len        = '0;
    abort        = 1'b0;
    result_ready = 1'b0;

    #3;
    chk_reset_vals("reset");
    chk("reset_perf", perf_cycles, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // k_len=3, ready high: full cycle-by-cycle trace
    start        = 1'b1;
    k_len        = 9'd3;
    result_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      for (int i = 0; i < SIZE; i++) exp_lane[i] = (c >= 3 + i) && (c <= 5 + i);
      exp_valid = (c >= 13) && (c <= 16);
      chk($sformatf("t1_busy_c%0d", c), busy, (c <= 17) ? 1 : 0);
      chk($sformatf("t1_array_clr_c%0d", c), array_clr, (c == 1) ? 1 : 0);
      chk($sformatf("t1_rd_en_c%0d", c), rd_en, (c >= 2 && c <= 4) ? 1 : 0);
      chk($sformatf("t1_rd_k_c%0d", c), rd_k, (c >= 2 && c <= 4) ? c - 2 : 0);
      chk($sformatf("t1_lane_en_c%0d", c), lane_en, exp_lane);
      chk($sformatf("t1_valid_c%0d", c), result_valid, exp_valid);
      chk($sformatf("t1_row_c%0d", c), result_row, exp_valid ? c - 13 : 0);
      chk($sformatf("t1_done_c%0d", c), done, (c == 17) ? 1 : 0);
      if (c < 18) tick();
    end
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("t1_perf", perf_cycles, 17);
    tick();
    chk("t1_perf_hold", perf_cycles, 17);
`endif

    // Invalid lengths: zero and K_MAX+1
    start = 1'b1;
    k_len = 9'd0;
    tick();
    start = 1'b0;
    chk("t2_zero_cmd_err", cmd_err, 1);
    chk("t2_zero_busy", busy, 0);
    chk("t2_zero_clr", array_clr, 0);
    tick();
    chk("t2_zero_cmd_err_end", cmd_err, 0);
    chk("t2_zero_busy_end", busy, 0);
    start = 1'b1;
    k_len = 9'd257;
    tick();
    start = 1'b0;
    chk("t2_big_cmd_err", cmd_err, 1);
    chk("t2_big_busy", busy, 0);
    tick();
    chk("t2_big_cmd_err_end", cmd_err, 0);
    chk("t2_big_busy_end", busy, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("t2_perf_hold", perf_cycles, 17);
`endif

    // Backpressure in DRAIN with ready pattern 1,0,0,1,...
    result_ready = 1'b0;
    start        = 1'b1;
    k_len        = 9'd1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!result_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t3_first_valid_cycle", cyc, 11);
    exp_row = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3_valid_i%0d", i), result_valid, 1);
      chk($sformatf("t3_row_i%0d", i), result_row, exp_row);
      chk($sformatf("t3_done_i%0d", i), done, 0);
      result_ready = ((i % 3) == 0);
      tick();
      if (result_ready) exp_row++;
    end
    result_ready = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_valid_after", result_valid, 0);
    tick();
    chk("t3_done_end", done, 0);
    chk("t3_busy_end", busy, 0);

    // Abort at FEED t=5
    result_ready = 1'b1;
    start        = 1'b1;
    k_len        = 9'd3;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("t4_lane_before_abort", lane_en, 4'b1100);
    chk("t4_busy_before_abort", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", busy, 0);
    chk("t4_lane_en", lane_en, 0);
    chk("t4_rd_en", rd_en, 0);
    chk("t4_array_clr", array_clr, 0);
    chk("t4_valid", result_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t4_no_done_%0d", i), done, 0);
      chk($sformatf("t4_lane_idle_%0d", i), lane_en, 0);
    end

    // start with abort while idle: start wins, then a clean run with k_len=2
    start = 1'b1;
    abort = 1'b1;
    k_len = 9'd2;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t4b_busy", busy, 1);
    chk("t4b_array_clr", array_clr, 1);
    done_at = 0;
    rd_cnt  = 0;
    for (int c = 1; c <= 20; c++) begin
      if (done && done_at == 0) done_at = c;
      if (rd_en) rd_cnt++;
      tick();
    end
    chk("t4b_done_cycle", done_at, 16);
    chk("t4b_rd_count", rd_cnt, 2);
    chk("t4b_idle", busy, 0);
`ifdef SYSTOLIC_CTRL_PERF_EN
    chk("t4b_perf", perf_cycles, 16);
`endif

    // Asynchronous reset during DRAIN row 2
    result_ready = 1'b1;
    start        = 1'b1;
    k_len        = 9'd3;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("t5_row2_valid", result_valid, 1);
    chk("t5_row2", result_row, 2);
    result_ready = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    chk("t5_perf", perf_cycles, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t5_busy_after", busy, 0);
    chk("t5_valid_after", result_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
